m220_xfer_ctl: RTL

- Register-transfer initiator that drives the control side of the M220 major-register slices: adder input selects, carry-in, shifter op selects and register load strobes.
- Accepts one encoded transfer request at a time and sequences selects → settle → load strobe → hold.
- Sits between major-state/timing logic and the chained M220 slices; one instance drives all slices in parallel.

---
 rtl/m220_xfer_ctl_pkg.sv | 71 +++++++
 rtl/m220_xfer_ctl_if.sv | 38 +++
 rtl/m220_xfer_ctl_dec.sv | 66 ++++++
 rtl/m220_xfer_ctl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/m220_xfer_ctl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m220_xfer_pkg : request encodings, one-hot bit indices and FSM states shared
// by the M220 transfer controller.                               Rev 1.0
// ----------------------------------------------------------------------------
package m220_xfer_pkg;

  typedef enum logic [2:0] {
    SRCA_NONE = 3'd0,
    SRCA_AC   = 3'd1,
    SRCA_AC_N = 3'd2,
    SRCA_MQ   = 3'd3,
    SRCA_SR   = 3'd4,
    SRCA_SC   = 3'd5,
    SRCA_DATA = 3'd6,
    SRCA_IO   = 3'd7
  } src_a_e;

  typedef enum logic [2:0] {
    SRCB_NONE      = 3'd0,
    SRCB_MA        = 3'd1,
    SRCB_PC        = 3'd2,
    SRCB_MEM       = 3'd3,
    SRCB_DATA_ADDR = 3'd4,
    SRCB_RSV5      = 3'd5,
    SRCB_RSV6      = 3'd6,
    SRCB_RSV7      = 3'd7
  } src_b_e;

  typedef enum logic [2:0] {
    SHOP_NOSH = 3'd0,
    SHOP_AND  = 3'd1,
    SHOP_SL   = 3'd2,
    SHOP_STL  = 3'd3,
    SHOP_SR   = 3'd4,
    SHOP_STR  = 3'd5,
    SHOP_TT   = 3'd6,
    SHOP_RSV  = 3'd7
  } shop_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } xfer_state_e;

  localparam int DEST_MA = 0;
  localparam int DEST_PC = 1;
  localparam int DEST_MB = 2;
  localparam int DEST_AC = 3;

  localparam int SHB_AND  = 0;
  localparam int SHB_NOSH = 1;
  localparam int SHB_SL   = 2;
  localparam int SHB_STL  = 3;
  localparam int SHB_SR   = 4;
  localparam int SHB_STR  = 5;

  localparam int SEL_A_W = 7;
  localparam int SEL_B_W = 4;
  localparam int SHOP_W  = 6;
  localparam int DEST_W  = 4;

  // Counter holds (cycles - 1), so the largest phase length needs clog2 bits.
  function automatic int cnt_width(input int max_cyc);
    return (max_cyc <= 1) ? 1 : $clog2(max_cyc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/m220_xfer_ctl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m220_xfer_if : request handshake plus slice-control bundle of the M220
// transfer controller (master = requester, slave = controller).  Rev 1.0
// ----------------------------------------------------------------------------
interface m220_xfer_if;
  import m220_xfer_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_src_a;
  logic [2:0]           req_src_b;
  logic                 req_cin;
  logic [2:0]           req_shop;
  logic [DEST_W-1:0]    req_dest;

  logic [SEL_A_W-1:0]   sel_a;
  logic [SEL_B_W-1:0]   sel_b;
  logic                 cin;
  logic [SHOP_W-1:0]    shop;
  logic                 tt_sh_n;
  logic [DEST_W-1:0]    ld;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output req_valid, req_src_a, req_src_b, req_cin, req_shop, req_dest,
    input  req_ready, sel_a, sel_b, cin, shop, tt_sh_n, ld, busy, done, err
  );

  modport slave (
    input  req_valid, req_src_a, req_src_b, req_cin, req_shop, req_dest,
    output req_ready, sel_a, sel_b, cin, shop, tt_sh_n, ld, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/m220_xfer_ctl_dec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m220_xfer_dec : combinational request-field to one-hot select decode and
// reserved/unusable request detect.                              Rev 1.0
// ----------------------------------------------------------------------------
module m220_xfer_dec
  import m220_xfer_pkg::*;
(
  input  logic [2:0]         src_a_i,
  input  logic [2:0]         src_b_i,
  input  logic [2:0]         shop_i,
  input  logic [DEST_W-1:0]  dest_i,
  output logic [SEL_A_W-1:0] sel_a_o,
  output logic [SEL_B_W-1:0] sel_b_o,
  output logic [SHOP_W-1:0]  shop_o,
  output logic               tt_sh_n_o,
  output logic               rsv_o
);

  always_comb begin
    sel_a_o = '0;
    case (src_a_e'(src_a_i))
      SRCA_AC:   sel_a_o[0] = 1'b1;
      SRCA_AC_N: sel_a_o[1] = 1'b1;
      SRCA_MQ:   sel_a_o[2] = 1'b1;
      SRCA_SR:   sel_a_o[3] = 1'b1;
      SRCA_SC:   sel_a_o[4] = 1'b1;
      SRCA_DATA: sel_a_o[5] = 1'b1;
      SRCA_IO:   sel_a_o[6] = 1'b1;
      default:   sel_a_o = '0;
    endcase
  end

  always_comb begin
    sel_b_o = '0;
    case (src_b_e'(src_b_i))
      SRCB_MA:        sel_b_o[0] = 1'b1;
      SRCB_PC:        sel_b_o[1] = 1'b1;
      SRCB_MEM:       sel_b_o[2] = 1'b1;
      SRCB_DATA_ADDR: sel_b_o[3] = 1'b1;
      default:        sel_b_o = '0;
    endcase
  end

  // TT is not a shifter function: it leaves the shift field empty and drives
  // the separate active-low line-shift enable instead.
  always_comb begin
    shop_o    = '0;
    tt_sh_n_o = 1'b1;
    case (shop_e'(shop_i))
      SHOP_NOSH: shop_o[SHB_NOSH] = 1'b1;
      SHOP_AND:  shop_o[SHB_AND]  = 1'b1;
      SHOP_SL:   shop_o[SHB_SL]   = 1'b1;
      SHOP_STL:  shop_o[SHB_STL]  = 1'b1;
      SHOP_SR:   shop_o[SHB_SR]   = 1'b1;
      SHOP_STR:  shop_o[SHB_STR]  = 1'b1;
      SHOP_TT:   tt_sh_n_o        = 1'b0;
      default:   shop_o = '0;
    endcase
  end

  assign rsv_o = (src_b_i >= 3'(SRCB_RSV5)) || (shop_i == 3'(SHOP_RSV)) ||
                 (dest_i == '0);

endmodule
`default_nettype wire

// File: rtl/m220_xfer_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// m220_xfer_ctl : sequences selects -> settle -> load strobe -> hold for the
// M220 slices; M220_XFER_ERRCHK_EN enables request rejection.     Rev 1.0
// ----------------------------------------------------------------------------
module m220_xfer_ctl
  import m220_xfer_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  m220_xfer_if.slave   bus
);

  localparam int MAX_CYC = (SETTLE_CYC > STROBE_CYC)
                         ? ((SETTLE_CYC > HOLD_CYC) ? int'(SETTLE_CYC) : int'(HOLD_CYC))
                         : ((STROBE_CYC > HOLD_CYC) ? int'(STROBE_CYC) : int'(HOLD_CYC));
  localparam int CNT_W = cnt_width(MAX_CYC);

  localparam logic [CNT_W-1:0] C_SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] C_STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LD   = CNT_W'(HOLD_CYC - 1);

`ifdef M220_XFER_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  xfer_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_A_W-1:0]  sel_a_q, sel_a_d;
  logic [SEL_B_W-1:0]  sel_b_q, sel_b_d;
  logic                cin_q, cin_d;
  logic [SHOP_W-1:0]   shop_q, shop_d;
  logic                tt_sh_n_q, tt_sh_n_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [DEST_W-1:0]   ld_q, ld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;

  logic [SEL_A_W-1:0]  w_sel_a;
  logic [SEL_B_W-1:0]  w_sel_b;
  logic [SHOP_W-1:0]   w_shop;
  logic                w_tt_sh_n;
  logic                w_rsv;
  logic                w_accept;
  logic                w_reject;

  m220_xfer_dec u_dec (
    .src_a_i   (bus.req_src_a),
    .src_b_i   (bus.req_src_b),
    .shop_i    (bus.req_shop),
    .dest_i    (bus.req_dest),
    .sel_a_o   (w_sel_a),
    .sel_b_o   (w_sel_b),
    .shop_o    (w_shop),
    .tt_sh_n_o (w_tt_sh_n),
    .rsv_o     (w_rsv)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    w_reject = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && ready_q) begin
          // A rejected request is consumed but never leaves IDLE.
          if (ERRCHK && w_rsv) begin
            w_reject = 1'b1;
          end else begin
            w_accept = 1'b1;
            state_d  = ST_SETTLE;
            cnt_d    = C_SETTLE_LD;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = C_STROBE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = C_HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    dest_d    = w_accept ? bus.req_dest : dest_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    cin_d     = cin_q;
    shop_d    = shop_q;
    tt_sh_n_d = tt_sh_n_q;
    if (state_d == ST_IDLE) begin
      sel_a_d   = '0;
      sel_b_d   = '0;
      cin_d     = 1'b0;
      shop_d    = '0;
      tt_sh_n_d = 1'b1;
    end else if (w_accept) begin
      sel_a_d   = w_sel_a;
      sel_b_d   = w_sel_b;
      cin_d     = bus.req_cin;
      shop_d    = w_shop;
      tt_sh_n_d = w_tt_sh_n;
    end

    ld_d    = (state_d == ST_STROBE) ? dest_q : '0;
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_HOLD) && (cnt_d == '0);
    err_d   = w_reject;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      cin_q     <= 1'b0;
      shop_q    <= '0;
      tt_sh_n_q <= 1'b1;
      dest_q    <= '0;
      ld_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      cin_q     <= cin_d;
      shop_q    <= shop_d;
      tt_sh_n_q <= tt_sh_n_d;
      dest_q    <= dest_d;
      ld_q      <= ld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.sel_a     = sel_a_q;
  assign bus.sel_b     = sel_b_q;
  assign bus.cin       = cin_q;
  assign bus.shop      = shop_q;
  assign bus.tt_sh_n   = tt_sh_n_q;
  assign bus.ld        = ld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef M220_XFER_ERRCHK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
`default_nettype wire
